// File: rtl/receiver_if.sv
// Serial-line side of the multi-byte UART receiver: the line input plus the
// word-level results. The line driver uses master, the receiver uses slave.
interface receiver_if #(
    parameter int N_BYTES = 16
);
    logic                   rx_pin;
    logic [N_BYTES*8-1:0]   rx_data;
    logic                   valid;
    logic                   frame_error;
    logic                   busy;

    modport master (
        output rx_pin,
        input  rx_data,
        input  valid,
        input  frame_error,
        input  busy
    );

    modport slave (
        input  rx_pin,
        output rx_data,
        output valid,
        output frame_error,
        output busy
    );
endinterface

// File: rtl/receiver.sv
// Multi-byte UART receiver (8N1, LSB first, idle high). Assembles N_BYTES
// frames into one word, first byte in the most-significant position, and
// presents it with a one-cycle valid pulse. A bad stop bit or an over-long
// idle gap between bytes of one word discards the partial word.
module receiver #(
    parameter int N_BYTES      = 16,
    parameter int CLKS_PER_BIT = 35,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic       clk,
    input  logic       reset,
    receiver_if.slave  bus
);
    localparam int W     = N_BYTES * 8;
    localparam int CNT_W = $clog2(CLKS_PER_BIT * TIMEOUT_BITS) + 1;
    localparam int BC_W  = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;

    localparam logic [CNT_W-1:0] HALF_BIT  = CNT_W'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CNT_W-1:0] BIT_END   = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] TO_END    = CNT_W'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
    localparam logic [BC_W-1:0]  LAST_BYTE = BC_W'(N_BYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       byte_q, byte_d;
    logic [W-1:0]     shift_q, shift_d;
    logic [BC_W-1:0]  byte_cnt_q, byte_cnt_d;
    logic [W-1:0]     rx_data_q, rx_data_d;
    logic             valid_q, valid_d;
    logic             frame_error_q, frame_error_d;
    logic [W-1:0]     word_next;
    logic             rxs;

    // Two-stage synchroniser for the asynchronous line; rxs is the only view
    // of the line the rest of the logic uses.
    always_comb begin
        sync_d = {sync_q[0], bus.rx_pin};
    end

    assign rxs = sync_q[1];

    // Frame FSM, bit sampling, idle timeout and word assembly.
    always_comb begin
        state_d       = state_q;
        clk_cnt_d     = clk_cnt_q + CNT_W'(1);
        bit_idx_d     = bit_idx_q;
        byte_d        = byte_q;
        shift_d       = shift_q;
        byte_cnt_d    = byte_cnt_q;
        rx_data_d     = rx_data_q;
        valid_d       = 1'b0;
        frame_error_d = 1'b0;
        word_next     = (shift_q << 8) | W'(byte_q);

        case (state_q)
            IDLE: begin
                if (!rxs) begin
                    state_d   = START;
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                end else if (byte_cnt_q != '0) begin
                    // Partial word waits for its next byte only so long.
                    if (clk_cnt_q == TO_END) begin
                        byte_cnt_d = '0;
                        shift_d    = '0;
                        clk_cnt_d  = '0;
                    end
                end else begin
                    clk_cnt_d = '0;
                end
            end
            START: begin
                // Re-check the line in the middle of the start bit to reject glitches.
                if (clk_cnt_q == HALF_BIT) begin
                    clk_cnt_d = '0;
                    state_d   = rxs ? IDLE : DATA;
                end
            end
            DATA: begin
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    byte_d    = {rxs, byte_q[7:1]};
                    bit_idx_d = bit_idx_q + 3'd1;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leave at mid stop bit so a directly following start edge is not missed.
                if (clk_cnt_q == BIT_END) begin
                    clk_cnt_d = '0;
                    state_d   = IDLE;
                    if (rxs) begin
                        if (byte_cnt_q == LAST_BYTE) begin
                            rx_data_d  = word_next;
                            valid_d    = 1'b1;
                            byte_cnt_d = '0;
                            shift_d    = '0;
                        end else begin
                            shift_d    = word_next;
                            byte_cnt_d = byte_cnt_q + BC_W'(1);
                        end
                    end else begin
                        frame_error_d = 1'b1;
                        byte_cnt_d    = '0;
                        shift_d       = '0;
                    end
                end
            end
            default: begin
                state_d   = IDLE;
                clk_cnt_d = '0;
            end
        endcase
    end

    // State and datapath registers; reset returns to an idle line with no word pending.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q        <= 2'b11;
            state_q       <= IDLE;
            clk_cnt_q     <= '0;
            bit_idx_q     <= '0;
            byte_q        <= '0;
            shift_q       <= '0;
            byte_cnt_q    <= '0;
            rx_data_q     <= '0;
            valid_q       <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            state_q       <= state_d;
            clk_cnt_q     <= clk_cnt_d;
            bit_idx_q     <= bit_idx_d;
            byte_q        <= byte_d;
            shift_q       <= shift_d;
            byte_cnt_q    <= byte_cnt_d;
            rx_data_q     <= rx_data_d;
            valid_q       <= valid_d;
            frame_error_q <= frame_error_d;
        end
    end

    assign bus.rx_data     = rx_data_q;
    assign bus.valid       = valid_q;
    assign bus.frame_error = frame_error_q;
    assign bus.busy        = (state_q != IDLE);

endmodule
